// File: rtl/video_scanout.sv
// Display timing and scan-out engine: H/V counters, ping-pong line-buffer reads with
// integer pixel replication, per-line fill requests and row-level underrun blanking.
module video_scanout #(
  parameter int H_PIXELS      = 800,
  parameter int H_FRONT_PORCH = 48,
  parameter int H_SYNC        = 32,
  parameter int H_BACK_PORCH  = 80,
  parameter int V_PIXELS      = 600,
  parameter int V_FRONT_PORCH = 3,
  parameter int V_SYNC        = 4,
  parameter int V_BACK_PORCH  = 11,
  parameter bit HSYNC_POL     = 1'b1,
  parameter bit VSYNC_POL     = 1'b1,
  parameter int SCALE_X       = 1,
  parameter int SCALE_Y       = 1,
  parameter int RD_LATENCY    = 1,
  parameter int PIXEL_W       = 24,
  parameter logic [PIXEL_W-1:0] BORDER_COLOR = 24'hFF00FF,
  localparam int SRC_W  = H_PIXELS / SCALE_X,
  localparam int SRC_H  = V_PIXELS / SCALE_Y,
  localparam int ADDR_W = $clog2(SRC_W),
  localparam int LINE_W = $clog2(SRC_H)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  lb_addr,
  output logic               lb_bank,
  input  logic [PIXEL_W-1:0] lb_q,
  output logic               line_req,
  output logic [LINE_W-1:0]  line_num,
  output logic               line_bank,
  input  logic               line_done,
  input  logic               underrun_clr,
  output logic               underrun,
  output logic               hsync,
  output logic               vsync,
  output logic               draw_area,
  output logic               frame_start,
  output logic [7:0]         red,
  output logic [7:0]         green,
  output logic [7:0]         blue
);

  localparam int H_TOTAL = H_PIXELS + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int V_TOTAL = V_PIXELS + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
  localparam int PIPE    = RD_LATENCY + 1;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int XSW     = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int YSW     = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

  localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  H_VIS    = HW'(H_PIXELS);
  localparam logic [HW-1:0]  HS_BEG   = HW'(H_PIXELS + H_FRONT_PORCH);
  localparam logic [HW-1:0]  HS_END   = HW'(H_PIXELS + H_FRONT_PORCH + H_SYNC);
  localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  V_VIS    = VW'(V_PIXELS);
  localparam logic [VW-1:0]  VS_BEG   = VW'(V_PIXELS + V_FRONT_PORCH);
  localparam logic [VW-1:0]  VS_END   = VW'(V_PIXELS + V_FRONT_PORCH + V_SYNC);
  localparam logic [VW-1:0]  SY_START = VW'(SRC_H);
  localparam logic [VW-1:0]  SY_LAST  = VW'(SRC_H - 1);
  localparam logic [XSW-1:0] XS_MAX   = XSW'(SCALE_X - 1);
  localparam logic [YSW-1:0] YS_MAX   = YSW'(SCALE_Y - 1);

  typedef struct packed {
    logic hs;
    logic vs;
    logic fs;
    logic bd;
  } ctl_t;

  localparam ctl_t CTL_RST = ctl_t'({~HSYNC_POL, ~VSYNC_POL, 2'b00});

  logic [HW-1:0]  h, sx;
  logic [VW-1:0]  v, sy;
  logic [XSW-1:0] xs;
  logic [YSW-1:0] ys;

  logic [1:0]        ready, ready_nxt;
  logic              pend, pend_bank;
  logic              row_blank;
  logic [LINE_W-1:0] line_num_q, req_num;

  logic              h_vis, v_vis, de0, row_start, bank_rdy, blank_now;
  logic              req_first, req_next;
  ctl_t              ctl0;
  logic [PIPE-1:0]   vld_pipe;
  ctl_t [PIPE-1:0]   ctl_pipe;
  logic [PIXEL_W-1:0] px;

  // Source coordinates track the raster with sub-counters instead of dividing.
  always_ff @(posedge clk) begin
    if (rst) begin
      h  <= '0;
      v  <= V_VIS;
      sx <= '0;
      xs <= '0;
      sy <= SY_START;
      ys <= '0;
    end else if (h == H_LAST) begin
      h  <= '0;
      sx <= '0;
      xs <= '0;
      if (v == V_LAST) begin
        v  <= '0;
        sy <= '0;
        ys <= '0;
      end else begin
        v <= v + VW'(1);
        if (ys == YS_MAX) begin
          ys <= '0;
          sy <= sy + VW'(1);
        end else begin
          ys <= ys + YSW'(1);
        end
      end
    end else begin
      h <= h + HW'(1);
      if (xs == XS_MAX) begin
        xs <= '0;
        sx <= sx + HW'(1);
      end else begin
        xs <= xs + XSW'(1);
      end
    end
  end

  always_comb begin
    h_vis     = (h < H_VIS);
    v_vis     = (v < V_VIS);
    de0       = h_vis && v_vis;
    row_start = (h == '0) && v_vis;
    bank_rdy  = ready[sy[0]];
    // the row decision is taken once at its first pixel and then held
    blank_now = row_start ? !bank_rdy : row_blank;
    req_first = (h == '0) && (v == V_VIS);
    req_next  = row_start && (ys == '0) && (sy < SY_LAST);
    req_num   = req_first ? '0 : LINE_W'(sy + VW'(1));

    ctl0    = CTL_RST;
    ctl0.hs = (h >= HS_BEG && h < HS_END) ? HSYNC_POL : ~HSYNC_POL;
    ctl0.vs = (v >= VS_BEG && v < VS_END) ? VSYNC_POL : ~VSYNC_POL;
    ctl0.fs = (h == '0) && (v == '0);
    ctl0.bd = de0 && blank_now;
  end

  assign line_req  = (req_first || req_next) && !rst;
  assign line_num  = line_req ? req_num : line_num_q;
  assign line_bank = line_num[0];

  // A done retires the old request before a coincident new request clears its bank.
  always_comb begin
    ready_nxt = ready;
    if (line_done && pend) ready_nxt[pend_bank] = 1'b1;
    if (line_req) ready_nxt[line_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready      <= '0;
      pend       <= 1'b0;
      pend_bank  <= 1'b0;
      line_num_q <= '0;
      row_blank  <= 1'b0;
      underrun   <= 1'b0;
      lb_addr    <= '0;
      lb_bank    <= 1'b0;
    end else begin
      ready <= ready_nxt;
      if (line_req) begin
        pend       <= 1'b1;
        pend_bank  <= line_bank;
        line_num_q <= req_num;
      end else if (line_done) begin
        pend <= 1'b0;
      end
      if (row_start) row_blank <= !bank_rdy;
      if (row_start && !bank_rdy) underrun <= 1'b1;
      else if (underrun_clr)      underrun <= 1'b0;
      lb_addr <= h_vis ? sx[ADDR_W-1:0] : '0;
      lb_bank <= sy[0];
    end
  end

  // Timing delayed to meet lb_q: one cycle of address register plus read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      ctl_pipe <= {PIPE{CTL_RST}};
    end else begin
      vld_pipe <= {vld_pipe[PIPE-2:0], de0};
      ctl_pipe <= {ctl_pipe[PIPE-2:0], ctl0};
    end
  end

  always_comb begin
    px = '0;
    if (vld_pipe[PIPE-1]) px = ctl_pipe[PIPE-1].bd ? BORDER_COLOR : lb_q;
  end

  assign draw_area   = vld_pipe[PIPE-1];
  assign hsync       = ctl_pipe[PIPE-1].hs;
  assign vsync       = ctl_pipe[PIPE-1].vs;
  assign frame_start = ctl_pipe[PIPE-1].fs;
  assign red         = px[PIXEL_W-1  -: 8];
  assign green       = px[PIXEL_W-9  -: 8];
  assign blue        = px[PIXEL_W-17 -: 8];

endmodule

// File: tb/tb_video_scanout.sv
// Scoreboard bench: the renderer model pushes expected rows per request, a monitor
// pops on draw_area; timing compared to a raster-position model for two configurations.
module tb_video_scanout;
  localparam logic [23:0] BORDER = 24'hFF00FF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line_done = 1'b0;
  logic underrun_clr = 1'b0;

  logic [1:0]  lb_addr, lb_addr2;
  logic        lb_bank, lb_bank2;
  logic [23:0] lb_q, lb_q2;
  logic        line_req, line_req2, line_bank, line_bank2;
  logic [0:0]  line_num, line_num2;
  logic        underrun, underrun2;
  logic        hsync, vsync, draw_area, frame_start;
  logic        hsync2, vsync2, draw_area2, frame_start2;
  logic [7:0]  red, green, blue, red2, green2, blue2;

  logic [23:0] mem [2][4];
  logic [23:0] q2p [4];
  logic [23:0] q1 [$];
  logic [23:0] q2 [$];

  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;
  bit running = 1'b0;
  bit withhold = 1'b0;

  always #5 clk = ~clk;

  video_scanout #(
    .H_PIXELS(8), .H_FRONT_PORCH(2), .H_SYNC(2), .H_BACK_PORCH(2),
    .V_PIXELS(4), .V_FRONT_PORCH(1), .V_SYNC(1), .V_BACK_PORCH(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .SCALE_X(2), .SCALE_Y(2), .RD_LATENCY(1)
  ) dut (
    .clk(clk), .rst(rst), .lb_addr(lb_addr), .lb_bank(lb_bank), .lb_q(lb_q),
    .line_req(line_req), .line_num(line_num), .line_bank(line_bank), .line_done(line_done),
    .underrun_clr(underrun_clr), .underrun(underrun), .hsync(hsync), .vsync(vsync),
    .draw_area(draw_area), .frame_start(frame_start), .red(red), .green(green), .blue(blue)
  );

  video_scanout #(
    .H_PIXELS(8), .H_FRONT_PORCH(2), .H_SYNC(2), .H_BACK_PORCH(2),
    .V_PIXELS(4), .V_FRONT_PORCH(1), .V_SYNC(1), .V_BACK_PORCH(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .SCALE_X(2), .SCALE_Y(2), .RD_LATENCY(4)
  ) dut2 (
    .clk(clk), .rst(rst), .lb_addr(lb_addr2), .lb_bank(lb_bank2), .lb_q(lb_q2),
    .line_req(line_req2), .line_num(line_num2), .line_bank(line_bank2), .line_done(line_done),
    .underrun_clr(underrun_clr), .underrun(underrun2), .hsync(hsync2), .vsync(vsync2),
    .draw_area(draw_area2), .frame_start(frame_start2), .red(red2), .green(green2), .blue(blue2)
  );

  // line-buffer RAMs: latency 1 and latency 4
  always @(posedge clk) begin
    lb_q   <= mem[lb_bank][lb_addr];
    q2p[0] <= mem[lb_bank2][lb_addr2];
    for (int i = 1; i < 4; i++) q2p[i] <= q2p[i-1];
  end
  assign lb_q2 = q2p[3];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic fill(input logic [0:0] ln);
    for (int x = 0; x < 4; x++) mem[ln][x] = 24'(x * 16 + int'(ln));
  endtask

  task automatic push_line(input logic [0:0] ln, input bit bd);
    logic [23:0] val;
    for (int r = 0; r < 2; r++)
      for (int hh = 0; hh < 8; hh++) begin
        val = bd ? BORDER : 24'((hh / 2) * 16 + int'(ln));
        q1.push_back(val);
        q2.push_back(val);
      end
  endtask

  // {hsync, vsync, draw_area, frame_start} for output cycle k after reset release
  function automatic logic [3:0] exp_tim(input int k, input int pipe, input bit hpol);
    int p, hh, vv;
    logic hs, vs, de, fs;
    if (k < pipe) return {~hpol, 1'b0, 1'b0, 1'b0};
    p  = (4 * 14 + k - pipe) % 98;
    hh = p % 14;
    vv = p / 14;
    de = (hh < 8) && (vv < 4);
    hs = (hh >= 10 && hh < 12) ? hpol : ~hpol;
    vs = (vv == 5);
    fs = (p == 0);
    return {hs, vs, de, fs};
  endfunction

  initial begin : renderer
    int dly;
    bit late;
    logic [0:0] cur_ln, late_ln;
    dly = -1;
    late = 1'b0;
    cur_ln = '0;
    late_ln = '0;
    for (int b = 0; b < 2; b++)
      for (int x = 0; x < 4; x++) mem[b][x] = '0;
    forever begin
      @(negedge clk);
      line_done = 1'b0;
      if (rst) begin
        dly = -1;
        late = 1'b0;
      end else begin
        if (dly > 0) dly--;
        else if (dly == 0) begin
          fill(cur_ln);
          line_done = 1'b1;
          dly = -1;
        end
        if (line_req) begin
          if (late) begin
            fill(late_ln);
            line_done = 1'b1;
            late = 1'b0;
          end
          if (withhold && line_num == 1'b1) begin
            withhold = 1'b0;
            late = 1'b1;
            late_ln = line_num;
            push_line(line_num, 1'b1);
          end else begin
            cur_ln = line_num;
            dly = 1;
            push_line(line_num, 1'b0);
          end
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (running) begin
        check("timing1", 32'({hsync, vsync, draw_area, frame_start}), 32'(exp_tim(n, 2, 1'b1)));
        check("timing2", 32'({hsync2, vsync2, draw_area2, frame_start2}), 32'(exp_tim(n, 5, 1'b0)));
        if (draw_area) begin
          if (q1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rgb1_empty at %0t: got pixel %0h expected none", $time, {red, green, blue});
          end else check("rgb1", 32'({red, green, blue}), 32'(q1.pop_front()));
        end else check("rgb1_off", 32'({red, green, blue}), 32'(0));
        if (draw_area2) begin
          if (q2.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rgb2_empty at %0t: got pixel %0h expected none", $time, {red2, green2, blue2});
          end else check("rgb2", 32'({red2, green2, blue2}), 32'(q2.pop_front()));
        end else check("rgb2_off", 32'({red2, green2, blue2}), 32'(0));
        n++;
      end
    end
  end

  initial begin : driver
    repeat (5) @(posedge clk);
    #1;
    check("rst_hsync", 32'(hsync), 32'(0));
    check("rst_vsync", 32'(vsync), 32'(0));
    check("rst_draw", 32'(draw_area), 32'(0));
    check("rst_req", 32'(line_req), 32'(0));
    check("rst_rgb", 32'({red, green, blue}), 32'(0));
    check("rst_hsync2", 32'(hsync2), 32'(1));
    check("rst_underrun", 32'(underrun), 32'(0));
    rst = 1'b0; n = 0; running = 1'b1;
    #1;
    check("req_first", 32'(line_req), 32'(1));
    check("req_first_num", 32'(line_num), 32'(0));
    check("req_first_bank", 32'(line_bank), 32'(0));

    repeat (196) @(posedge clk);
    #1 check("underrun_clean", 32'(underrun), 32'(0));

    withhold = 1'b1;
    repeat (196) @(posedge clk);
    #1 check("underrun_set", 32'(underrun), 32'(1));
    check("underrun_set2", 32'(underrun2), 32'(1));
    underrun_clr = 1'b1;
    @(posedge clk);
    #1 underrun_clr = 1'b0;
    check("underrun_clr", 32'(underrun), 32'(0));
    repeat (196) @(posedge clk);
    #1 check("underrun_stays_clr", 32'(underrun), 32'(0));

    for (int i = 0; i < 200 && !draw_area; i++) begin
      @(posedge clk);
      #1;
    end
    check("found_draw", 32'(draw_area), 32'(1));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; running = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_draw", 32'(draw_area), 32'(0));
    check("midrst_rgb", 32'({red, green, blue}), 32'(0));
    check("midrst_hsync", 32'(hsync), 32'(0));
    check("midrst_hsync2", 32'(hsync2), 32'(1));
    check("midrst_req", 32'(line_req), 32'(0));
    check("midrst_addr", 32'({lb_bank, lb_addr}), 32'(0));
    q1.delete();
    q2.delete();
    withhold = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0; n = 0; running = 1'b1;
    #1 check("req_after_rst", 32'(line_req), 32'(1));
    check("req_after_rst_num", 32'(line_num), 32'(0));
    repeat (196) @(posedge clk);
    #1 check("underrun_after_rst", 32'(underrun), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
